// File: rtl/dmem_responder.sv
// Memory-side responder: one outstanding request, a programmable number of wait
// states, then a 64-bit read or byte-masked write on synthesizable word storage.
module dmem_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000000080000000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [63:0] SPAN  = 64'(8) << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_write;
  logic [63:0]           lat_addr;
  logic [63:0]           lat_wdata;
  logic [7:0]            lat_wmask;
  logic [63:0]           mem [DEPTH];

  logic                  accept_c;
  logic                  commit_c;
  logic                  in_range_c;
  logic [63:0]           off_c;
  logic [DEPTH_LOG2-1:0] idx_c;

  // Decode is done on the latched address, so later request changes cannot leak in.
  assign off_c      = lat_addr - BASE_ADDR;
  assign in_range_c = (lat_addr >= BASE_ADDR) && (off_c < SPAN);
  assign idx_c      = off_c[DEPTH_LOG2+2:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    commit_c   = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept_c   = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (cnt == '0) begin
        commit_c   = 1'b1;
        state_next = RESP;
      end
      RESP: if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags track the next state so they are plain flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else begin
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      if (accept_c) begin
        cnt       <= CNT_W'(LATENCY);
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_wmask <= req_wmask;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit_c) begin
        resp_err   <= !in_range_c;
        resp_rdata <= (in_range_c && !lat_write) ? mem[idx_c] : '0;
      end
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (commit_c && lat_write && in_range_c) begin
      for (int b = 0; b < 8; b++) begin
        if (lat_wmask[b]) mem[idx_c][8*b +: 8] <= lat_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances with LATENCY 2, 3 and 0,
// directed vector table, hand-written corner sequences and a randomized model check.
module tb_dmem_responder;

  localparam logic [63:0] BASE = 64'h0000000080000000;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n      [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [63:0] req_addr   [3];
  logic [63:0] req_wdata  [3];
  logic [7:0]  req_wmask  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [63:0] resp_rdata [3];
  logic        resp_err   [3];

  int unsigned lat_tab [3] = '{2, 3, 0};
  logic [63:0] model [3][8];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(
      .BASE_ADDR (BASE),
      .DEPTH_LOG2(10),
      .LATENCY   (g == 0 ? 2 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wmask (req_wmask[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Present a request, let it be accepted, return edges until resp_valid (0 = timeout).
  task automatic issue(input int i, input logic w, input logic [63:0] a, input logic [63:0] d,
                       input logic [7:0] m, output int n);
    @(negedge clk);
    check("req_ready_before_accept", 64'(req_ready[i]), 64'd1);
    req_valid[i] = 1'b1; req_write[i] = w; req_addr[i] = a;
    req_wdata[i] = d;    req_wmask[i] = m;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'($urandom_range(0, 1));
    req_write[i] = ~w;
    req_addr[i]  = {$urandom, $urandom};
    req_wdata[i] = {$urandom, $urandom};
    req_wmask[i] = 8'($urandom);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid[i]) begin
        n = k;
        break;
      end
    end
    if (n == 0) check("resp_timeout", 64'd0, 64'd1);
  endtask

  task automatic complete(input int i);
    req_valid[i]  = 1'b0;
    resp_ready[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready[i] = 1'b0;
    check("resp_valid_after_take", 64'(resp_valid[i]), 64'd0);
    check("req_ready_after_take", 64'(req_ready[i]), 64'd1);
  endtask

  task automatic do_txn(input int i, input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] m, output logic [63:0] rd, output logic er);
    int n;
    issue(i, w, a, d, m, n);
    rd = resp_rdata[i];
    er = resp_err[i];
    check("latency", 64'(n), 64'(lat_tab[i] + 1));
    if (n != 0) complete(i);
    else req_valid[i] = 1'b0;
  endtask

  initial begin
    vec_t        vecs [$];
    logic [63:0] rd, held;
    logic        er;
    int          n;

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0; req_wmask[i] = '0; resp_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
      check("rst_req_ready", 64'(req_ready[i]), 64'd1);
      check("rst_rdata", resp_rdata[i], 64'd0);
      check("rst_err", 64'(resp_err[i]), 64'd0);
    end
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Directed table on the LATENCY=2 instance.
    vecs.push_back('{1'b1, 64'h80000010, 64'h1122334455667788, 8'hFF, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h80000010, 64'd0, 8'h00, 64'h1122334455667788, 1'b0});
    vecs.push_back('{1'b1, 64'h80000010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h80000010, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0});
    vecs.push_back('{1'b0, 64'h80000014, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0});
    vecs.push_back('{1'b1, 64'h80000010, 64'hDEADBEEFDEADBEEF, 8'h00, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h80000010, 64'd0, 8'h00, 64'h11223344AAAAAAAA, 1'b0});
    vecs.push_back('{1'b1, 64'h80000000, 64'h0123456789ABCDEF, 8'hFF, 64'd0, 1'b0});
    vecs.push_back('{1'b1, 64'h80001FF8, 64'hCAFEBABE55AA00FF, 8'hFF, 64'd0, 1'b0});
    vecs.push_back('{1'b0, 64'h80001FF8, 64'd0, 8'h00, 64'hCAFEBABE55AA00FF, 1'b0});
    vecs.push_back('{1'b0, 64'h80002000, 64'd0, 8'h00, 64'd0, 1'b1});
    vecs.push_back('{1'b1, 64'h7FFFFFF8, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'd0, 1'b1});
    vecs.push_back('{1'b0, 64'h80000000, 64'd0, 8'h00, 64'h0123456789ABCDEF, 1'b0});
    foreach (vecs[v]) begin
      do_txn(0, vecs[v].write, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, rd, er);
      check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("vec%0d_err", v), 64'(er), 64'(vecs[v].exp_err));
    end

    // Backpressure: response held while request side is toggled.
    issue(0, 1'b0, 64'h80000000, 64'd0, 8'h00, n);
    for (int c = 0; c < 5; c++) begin
      req_valid[0] = ~req_valid[0];
      req_write[0] = 1'($urandom);
      req_addr[0]  = 64'h80000000 + 64'(8 * c);
      @(posedge clk);
      @(negedge clk);
      check("bp_resp_valid", 64'(resp_valid[0]), 64'd1);
      check("bp_rdata", resp_rdata[0], 64'h0123456789ABCDEF);
      check("bp_err", 64'(resp_err[0]), 64'd0);
      check("bp_req_ready", 64'(req_ready[0]), 64'd0);
    end
    complete(0);
    repeat (3) begin
      @(negedge clk);
      check("bp_no_extra_accept", 64'(resp_valid[0]), 64'd0);
    end

    // Reset while a response is pending.
    issue(0, 1'b0, 64'h80000010, 64'd0, 8'h00, n);
    held = resp_rdata[0];
    check("pre_rst_rdata", held, 64'h11223344AAAAAAAA);
    rst_n[0] = 1'b0;
    #1;
    check("mid_rst_resp_valid", 64'(resp_valid[0]), 64'd0);
    check("mid_rst_rdata", resp_rdata[0], 64'd0);
    check("mid_rst_err", 64'(resp_err[0]), 64'd0);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    #1;
    check("post_rst_req_ready", 64'(req_ready[0]), 64'd1);

    // Reset during WAIT drops the pending write (LATENCY=3 instance).
    do_txn(1, 1'b1, 64'h80000020, 64'h0F0E0D0C0B0A0908, 8'hFF, rd, er);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 64'h80000020;
    req_wdata[1] = 64'h5555555555555555; req_wmask[1] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    check("wait_rst_resp_valid", 64'(resp_valid[1]), 64'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("wait_rst_no_resp", 64'(resp_valid[1]), 64'd0);
    end
    do_txn(1, 1'b0, 64'h80000020, 64'd0, 8'h00, rd, er);
    check("wait_rst_prior_data", rd, 64'h0F0E0D0C0B0A0908);
    check("wait_rst_prior_err", 64'(er), 64'd0);

    // Zero-latency instance.
    do_txn(2, 1'b1, 64'h80000010, 64'h1122334455667788, 8'hFF, rd, er);
    check("lat0_wr_rdata", rd, 64'd0);
    check("lat0_wr_err", 64'(er), 64'd0);
    do_txn(2, 1'b0, 64'h80000010, 64'd0, 8'h00, rd, er);
    check("lat0_rd_rdata", rd, 64'h1122334455667788);

    // Randomized traffic against a word-array model.
    for (int i = 0; i < 3; i += 2) begin
      for (int w = 0; w < 8; w++) begin
        model[i][w] = {$urandom, $urandom};
        do_txn(i, 1'b1, BASE + 64'(8 * w), model[i][w], 8'hFF, rd, er);
      end
      for (int t = 0; t < 40; t++) begin
        int          sel, idx;
        logic        w;
        logic [63:0] a, d, exp_rd;
        logic [7:0]  m;
        logic        ok;
        sel = int'($urandom_range(0, 9));
        idx = int'($urandom_range(0, 7));
        w   = 1'($urandom);
        d   = {$urandom, $urandom};
        m   = 8'($urandom);
        ok  = (sel < 8);
        if (sel < 8)       a = BASE + 64'(8 * idx) + 64'($urandom_range(0, 7));
        else if (sel == 8) a = BASE - 64'(8 * (idx + 1));
        else               a = BASE + 64'h2000 + 64'(8 * idx);
        do_txn(i, w, a, d, m, rd, er);
        exp_rd = (ok && !w) ? model[i][idx] : 64'd0;
        if (ok && w) model[i][idx] = merge(model[i][idx], d, m);
        check($sformatf("rand%0d_%0d_rdata", i, t), rd, exp_rd);
        check($sformatf("rand%0d_%0d_err", i, t), 64'(er), 64'(!ok));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
